// File: rtl/pipeline_mon_pkg.sv
// pipeline_mon_pkg: shared state encoding, fail codes and forwarding-none encoding for the run monitor
package pipeline_mon_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PASS = 2'd2, ST_FAIL = 2'd3} state_e;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_HANG = 2'd2;
  localparam logic [1:0] FC_PROTO = 2'd3;
  localparam logic [1:0] FWD_NONE = 2'b00;
endpackage

// File: rtl/mon_sat_counter.sv
// mon_sat_counter: W-bit saturating counter; clk/rst, clr zeroes, inc adds 0..2, cnt is the registered value
module mon_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0] sum;
  always_comb begin
    sum = {1'b0, cnt_q} + (W+1)'(inc);
    cnt_d = clr ? '0 : sum[W] ? '1 : sum[W-1:0];
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_run_monitor.sv
// pipeline_run_monitor: samples pc/pc_valid/branch/mispredict/jump/retire/fwd_a/fwd_b, counts events, traces PCs (trace_rd_idx -> trace_rd_pc), reports state/done/fail_code
module pipeline_run_monitor
  import pipeline_mon_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 32,
  parameter logic [XLEN-1:0] END_PC = 32'h0000_0020,
  parameter int TIMEOUT = 1000,
  parameter int STALL_LIMIT = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [XLEN-1:0]                pc,
  input  logic                           pc_valid,
  input  logic                           branch,
  input  logic                           mispredict,
  input  logic                           jump,
  input  logic                           retire,
  input  logic [1:0]                     fwd_a,
  input  logic [1:0]                     fwd_b,
  input  logic                           clear,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               retire_cnt,
  output logic [CNT_W-1:0]               branch_cnt,
  output logic [CNT_W-1:0]               mispred_cnt,
  output logic [CNT_W-1:0]               jump_cnt,
  output logic [CNT_W-1:0]               fwd_cnt,
  output logic [1:0]                     state,
  output logic                           done,
  output logic [1:0]                     fail_code
);
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  state_e state_q, state_d;
  logic [1:0] fail_code_q, fail_code_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] trace_q [TRACE_DEPTH];
  logic [XLEN-1:0] trace_d [TRACE_DEPTH];
  logic counted, clr, progress, hang, tmo;
  logic [1:0] inc [6];
  logic [CNT_W-1:0] cnt [6];
  always_comb begin
    counted = state_q == ST_RUN || (state_q == ST_IDLE && pc_valid);
    clr = clear && !done;
    progress = pc_valid && pc != last_pc_q;
    // both exits look at the value the counter would take this cycle, so a clear defuses them
    hang = !clr && !progress && stall_q == SW'(STALL_LIMIT - 1);
    tmo = !clr && cycle_cnt != '1 && 64'(cycle_cnt) + 64'd1 == 64'(TIMEOUT);
    inc[0] = {1'b0, counted};
    inc[1] = {1'b0, counted && retire};
    inc[2] = {1'b0, counted && branch};
    inc[3] = {1'b0, counted && mispredict};
    inc[4] = {1'b0, counted && jump};
    inc[5] = counted ? 2'(fwd_a != FWD_NONE) + 2'(fwd_b != FWD_NONE) : 2'd0;
    state_d = state_q;
    fail_code_d = fail_code_q;
    stall_d = stall_q;
    last_pc_d = last_pc_q;
    wr_ptr_d = wr_ptr_q;
    trace_d = trace_q;
    if (counted) begin
      stall_d = clr || progress ? '0 : stall_q + SW'(1);
      last_pc_d = progress ? pc : last_pc_q;
      if (pc_valid) begin
        trace_d[wr_ptr_q] = pc;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      state_d = ST_RUN;
      if (pc_valid && pc == END_PC) state_d = ST_PASS;
      else if (mispredict && !branch) begin
        state_d = ST_FAIL;
        fail_code_d = FC_PROTO;
      end else if (hang) begin
        state_d = ST_FAIL;
        fail_code_d = FC_HANG;
      end else if (tmo) begin
        state_d = ST_FAIL;
        fail_code_d = FC_TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fail_code_q <= FC_NONE;
      stall_q <= '0;
      last_pc_q <= '0;
      wr_ptr_q <= '0;
      trace_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      fail_code_q <= fail_code_d;
      stall_q <= stall_d;
      last_pc_q <= last_pc_d;
      wr_ptr_q <= wr_ptr_d;
      trace_q <= trace_d;
    end
  end
  for (genvar i = 0; i < 6; i++) begin : g_cnt
    mon_sat_counter #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .clr(clr), .inc(inc[i]), .cnt(cnt[i]));
  end
  assign cycle_cnt = cnt[0];
  assign retire_cnt = cnt[1];
  assign branch_cnt = cnt[2];
  assign mispred_cnt = cnt[3];
  assign jump_cnt = cnt[4];
  assign fwd_cnt = cnt[5];
  assign state = state_q;
  assign done = state_q == ST_PASS || state_q == ST_FAIL;
  assign fail_code = fail_code_q;
  assign trace_rd_pc = trace_q[wr_ptr_q - AW'(1) - trace_rd_idx];
endmodule

// File: tb/tb_pipeline_run_monitor.sv
// tb_pipeline_run_monitor: directed scenario tasks against three monitor configurations
module tb_pipeline_run_monitor;
  logic clk = 0, rst = 1, pc_valid = 0, branch = 0, mispredict = 0, jump = 0, retire = 0, clear = 0;
  logic [31:0] pc = 0;
  logic [1:0] fwd_a = 0, fwd_b = 0;
  logic [2:0] idx = 0;
  logic [31:0] d_tr, d_cyc, d_ret, d_br, d_mp, d_jmp, d_fwd;
  logic [31:0] t_tr, t_cyc, t_ret, t_br, t_mp, t_jmp, t_fwd;
  logic [31:0] s_tr;
  logic [3:0] s_cyc, s_ret, s_br, s_mp, s_jmp, s_fwd;
  logic [1:0] d_st, d_fc, t_st, t_fc, s_st, s_fc;
  logic d_done, t_done, s_done;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pipeline_run_monitor u_d (.clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .branch(branch),
    .mispredict(mispredict), .jump(jump), .retire(retire), .fwd_a(fwd_a), .fwd_b(fwd_b), .clear(clear),
    .trace_rd_idx(idx), .trace_rd_pc(d_tr), .cycle_cnt(d_cyc), .retire_cnt(d_ret), .branch_cnt(d_br),
    .mispred_cnt(d_mp), .jump_cnt(d_jmp), .fwd_cnt(d_fwd), .state(d_st), .done(d_done), .fail_code(d_fc));
  pipeline_run_monitor #(.TIMEOUT(20)) u_t (.clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .branch(branch),
    .mispredict(mispredict), .jump(jump), .retire(retire), .fwd_a(fwd_a), .fwd_b(fwd_b), .clear(clear),
    .trace_rd_idx(idx), .trace_rd_pc(t_tr), .cycle_cnt(t_cyc), .retire_cnt(t_ret), .branch_cnt(t_br),
    .mispred_cnt(t_mp), .jump_cnt(t_jmp), .fwd_cnt(t_fwd), .state(t_st), .done(t_done), .fail_code(t_fc));
  pipeline_run_monitor #(.CNT_W(4)) u_s (.clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .branch(branch),
    .mispredict(mispredict), .jump(jump), .retire(retire), .fwd_a(fwd_a), .fwd_b(fwd_b), .clear(clear),
    .trace_rd_idx(idx), .trace_rd_pc(s_tr), .cycle_cnt(s_cyc), .retire_cnt(s_ret), .branch_cnt(s_br),
    .mispred_cnt(s_mp), .jump_cnt(s_jmp), .fwd_cnt(s_fwd), .state(s_st), .done(s_done), .fail_code(s_fc));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    pc_valid = 0; branch = 0; mispredict = 0; jump = 0; retire = 0; clear = 0;
    fwd_a = 0; fwd_b = 0; pc = 0; idx = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (d_st !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", d_st); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", d_done); end
    checks++; if (d_fc !== 2'd0) begin errors++; $display("FAIL reset_fc got=%0d want=0", d_fc); end
    checks++; if ({d_cyc, d_ret, d_fwd} !== 96'd0) begin errors++; $display("FAIL reset_cnts got=%0h/%0h/%0h want=0", d_cyc, d_ret, d_fwd); end
    checks++; if (d_tr !== 32'd0) begin errors++; $display("FAIL reset_trace got=%0h want=0", d_tr); end
    tick();
    checks++; if (d_st !== 2'd0) begin errors++; $display("FAIL idle_hold got=%0d want=0", d_st); end
  endtask
  task automatic test_nominal();
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      pc = 32'(i * 4);
      pc_valid = 1;
      tick();
      if (i == 7) begin
        checks++; if (d_st !== 2'd1 || d_done !== 1'b0) begin errors++; $display("FAIL nom_prepass got=%0d/%0b want=1/0", d_st, d_done); end
      end
    end
    checks++; if (d_st !== 2'd2 || d_done !== 1'b1) begin errors++; $display("FAIL nom_pass got=%0d/%0b want=2/1", d_st, d_done); end
    checks++; if (d_cyc !== 32'd9) begin errors++; $display("FAIL nom_cycles got=%0d want=9", d_cyc); end
    checks++; if (d_fc !== 2'd0) begin errors++; $display("FAIL nom_fc got=%0d want=0", d_fc); end
    idx = 0; #1;
    checks++; if (d_tr !== 32'h20) begin errors++; $display("FAIL nom_trace0 got=%0h want=20", d_tr); end
    idx = 1; #1;
    checks++; if (d_tr !== 32'h1C) begin errors++; $display("FAIL nom_trace1 got=%0h want=1c", d_tr); end
    idx = 7; #1;
    checks++; if (d_tr !== 32'h04) begin errors++; $display("FAIL nom_trace_wrap got=%0h want=4", d_tr); end
    pc = 32'h100; retire = 1;
    tick();
    tick();
    checks++; if (d_cyc !== 32'd9 || d_ret !== 32'd0 || d_st !== 2'd2) begin errors++; $display("FAIL nom_frozen got=%0d/%0d/%0d want=9/0/2", d_cyc, d_ret, d_st); end
  endtask
  task automatic test_fwd_branch();
    logic [1:0] fa [5];
    logic [1:0] fb [5];
    logic [4:0] br, mp, jp, rt;
    fa = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    fb = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    br = 5'b01111; mp = 5'b00001; jp = 5'b00101; rt = 5'b01010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc = 32'h100 + 32'(i * 4); pc_valid = 1;
      fwd_a = fa[i]; fwd_b = fb[i];
      branch = br[i]; mispredict = mp[i]; jump = jp[i]; retire = rt[i];
      tick();
    end
    idle_inputs();
    checks++; if (d_fwd !== 32'd8) begin errors++; $display("FAIL fwd_cnt got=%0d want=8", d_fwd); end
    checks++; if (d_br !== 32'd4) begin errors++; $display("FAIL branch_cnt got=%0d want=4", d_br); end
    checks++; if (d_mp !== 32'd1) begin errors++; $display("FAIL mispred_cnt got=%0d want=1", d_mp); end
    checks++; if (d_jmp !== 32'd2) begin errors++; $display("FAIL jump_cnt got=%0d want=2", d_jmp); end
    checks++; if (d_ret !== 32'd2 || d_cyc !== 32'd5) begin errors++; $display("FAIL fb_ret_cyc got=%0d/%0d want=2/5", d_ret, d_cyc); end
    checks++; if (d_st !== 2'd1) begin errors++; $display("FAIL fb_state got=%0d want=1", d_st); end
  endtask
  task automatic test_hang();
    do_reset();
    pc_valid = 1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++; if (d_st !== 2'd1) begin errors++; $display("FAIL hang_early got=%0d want=1", d_st); end
      end
    end
    checks++; if (d_st !== 2'd3 || d_fc !== 2'd2) begin errors++; $display("FAIL hang_fail got=%0d/%0d want=3/2", d_st, d_fc); end
    checks++; if (d_cyc !== 32'd19) begin errors++; $display("FAIL hang_cycles got=%0d want=19", d_cyc); end
    pc = 32'h40; retire = 1; clear = 1;
    tick();
    tick();
    checks++; if (d_cyc !== 32'd19 || d_ret !== 32'd0 || d_st !== 2'd3) begin errors++; $display("FAIL hang_frozen got=%0d/%0d/%0d want=19/0/3", d_cyc, d_ret, d_st); end
  endtask
  task automatic test_timeout();
    do_reset();
    pc_valid = 1;
    for (int i = 1; i <= 20; i++) begin
      pc = 32'h100 + 32'(i * 4);
      tick();
      if (i == 19) begin
        checks++; if (t_st !== 2'd1) begin errors++; $display("FAIL tmo_early got=%0d want=1", t_st); end
      end
    end
    checks++; if (t_st !== 2'd3 || t_fc !== 2'd1) begin errors++; $display("FAIL tmo_fail got=%0d/%0d want=3/1", t_st, t_fc); end
    checks++; if (t_cyc !== 32'd20) begin errors++; $display("FAIL tmo_cycles got=%0d want=20", t_cyc); end
  endtask
  task automatic test_protocol();
    do_reset();
    pc = 32'h100; pc_valid = 1;
    tick();
    idx = 1; #1;
    checks++; if (d_tr !== 32'd0) begin errors++; $display("FAIL unwritten_trace got=%0h want=0", d_tr); end
    pc = 32'h104; mispredict = 1; branch = 0;
    tick();
    checks++; if (d_st !== 2'd3 || d_fc !== 2'd3) begin errors++; $display("FAIL proto_fail got=%0d/%0d want=3/3", d_st, d_fc); end
    do_reset();
    pc = 32'h100; pc_valid = 1;
    tick();
    pc = 32'h20; mispredict = 1;
    tick();
    checks++; if (d_st !== 2'd2 || d_fc !== 2'd0) begin errors++; $display("FAIL pass_priority got=%0d/%0d want=2/0", d_st, d_fc); end
  endtask
  task automatic test_saturation();
    do_reset();
    pc_valid = 1; retire = 1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'h100 + 32'(i * 4);
      tick();
    end
    checks++; if (s_ret !== 4'd15 || s_cyc !== 4'd15) begin errors++; $display("FAIL sat_cnt got=%0d/%0d want=15/15", s_ret, s_cyc); end
    clear = 1; pc = 32'h200;
    tick();
    checks++; if (s_ret !== 4'd0 || s_cyc !== 4'd0 || s_st !== 2'd1) begin errors++; $display("FAIL clear got=%0d/%0d/%0d want=0/0/1", s_ret, s_cyc, s_st); end
    clear = 0; pc = 32'h204;
    tick();
    checks++; if (s_ret !== 4'd1) begin errors++; $display("FAIL post_clear got=%0d want=1", s_ret); end
    rst = 1;
    tick();
    rst = 0; idle_inputs();
    #1;
    checks++; if (s_st !== 2'd0 || s_done !== 1'b0 || s_fc !== 2'd0) begin errors++; $display("FAIL rst_midrun got=%0d/%0b/%0d want=0/0/0", s_st, s_done, s_fc); end
    checks++; if (s_ret !== 4'd0 || s_cyc !== 4'd0 || s_tr !== 32'd0) begin errors++; $display("FAIL rst_midrun_cnt got=%0d/%0d/%0h want=0/0/0", s_ret, s_cyc, s_tr); end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_fwd_branch();
    test_hang();
    test_timeout();
    test_protocol();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_run_monitor.md
Name: pipeline_run_monitor

Overview:
- Synthesizable run monitor that sits beside pipeline_cpu and samples its fetch PC, branch/jump resolution and forwarding selects every cycle.
- Keeps saturating performance counters and a ring buffer of the last N fetched PCs.
- Declares pass when the PC reaches a programmable end address; declares fail on timeout, PC hang, or a control-protocol violation.
- Replaces ad-hoc per-cycle printing and end-PC checks in benches; also usable on FPGA as a debug core.

Parameters:
- XLEN, 32, PC width.
- CNT_W, 32, width of every event counter.
- END_PC, 32'h0000_0020, PC value that signals test completion.
- TIMEOUT, 1000, maximum RUN cycles before fail; must be ≥ 1.
- STALL_LIMIT, 16, consecutive RUN cycles without PC progress before fail; must be ≥ 1.
- TRACE_DEPTH, 8, ring-buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  XLEN  current fetch PC.
- pc_valid  in  1  pc is a real fetch this cycle (low during stall/flush bubble).
- branch  in  1  a branch resolved this cycle.
- mispredict  in  1  the resolved branch was mispredicted.
- jump  in  1  a jump resolved this cycle.
- retire  in  1  one instruction wrote back this cycle.
- fwd_a  in  2  forwarding select, operand A (00 = none).
- fwd_b  in  2  forwarding select, operand B (00 = none).
- clear  in  1  synchronous clear of counters and stall counter.
- trace_rd_idx  in  $clog2(TRACE_DEPTH)  0 = most recent PC.
- trace_rd_pc  out  XLEN  PC at trace_rd_idx (combinational read).
- cycle_cnt, retire_cnt, branch_cnt, mispred_cnt, jump_cnt, fwd_cnt  out  CNT_W each  event counters.
- state  out  2  IDLE=0, RUN=1, PASS=2, FAIL=3.
- done  out  1  state is PASS or FAIL.
- fail_code  out  2  0 none, 1 timeout, 2 hang, 3 protocol.

Behaviour:
- Reset: state=IDLE, every counter 0, fail_code=0, done=0, trace entries 0, write pointer 0, stall counter 0, last_pc 0.
- IDLE→RUN on the first cycle with pc_valid=1. That cycle counts as the first RUN cycle: its events are counted and its PC is traced.
- Events are counted only in cycles whose start-of-cycle state is IDLE-transitioning or RUN. PASS and FAIL are terminal and freeze all counters and the trace until rst.
- RUN exit checks are evaluated in the same cycle. Priority, highest first:
  1. pass: pc_valid && pc==END_PC → PASS.
  2. protocol: mispredict && !branch → FAIL, code 3.
  3. hang: stall counter would reach STALL_LIMIT → FAIL, code 2.
  4. timeout: cycle_cnt would reach TIMEOUT → FAIL, code 1.
- Counters update on the transition cycle itself. done and state are registered, so both reflect the new state one cycle after the triggering sample.
- cycle_cnt: +1 every counted cycle.
- retire_cnt, branch_cnt, mispred_cnt, jump_cnt: +1 when the respective input is high.
- fwd_cnt: + (fwd_a!=0) + (fwd_b!=0), so 0, 1 or 2 per cycle.
- All counters saturate at 2^CNT_W−1 and never wrap.
- Stall counter:
  - Resets to 0 on pc_valid && pc!=last_pc, which also loads last_pc.
  - Otherwise +1 (includes pc_valid=0 cycles).
  - Not exposed.
- Trace:
  - On each counted cycle with pc_valid, write pc at wr_ptr, then wr_ptr+1 mod TRACE_DEPTH.
  - Read entry = (wr_ptr−1−trace_rd_idx) mod TRACE_DEPTH.
  - Entries never written read 0. After more than TRACE_DEPTH writes, oldest entries are overwritten.
- clear:
  - Zeroes the six counters and the stall counter. Does not change state, fail_code, trace or last_pc.
  - When clear and events occur in the same cycle, clear wins and the events are lost.
  - Ignored in PASS/FAIL.
- rst mid-run: abandons the run and returns to the reset values on the next edge, regardless of state.

Decomposition:
- Package pipeline_mon_pkg holds:
  - state enum (IDLE/RUN/PASS/FAIL);
  - fail-code constants (FC_NONE/TIMEOUT/HANG/PROTO);
  - the fwd "none" encoding 2'b00.
- Sub-module mon_sat_counter (parameter W; inputs clr, inc amount 0..2; saturating) is instantiated six times.
- Trace ring stays inline.

Test Plan:
- Nominal run: rst 2 cycles, then pc = 0,4,8,…,0x20 with pc_valid=1 every cycle → PASS on the 0x20 sample; done=1 one cycle later; cycle_cnt=9; fail_code=0; trace_rd_idx=0 reads 0x20, idx=1 reads 0x1C.
- Forwarding and branches:
  - stimulus: fwd_a=01, fwd_b=10 for 3 cycles; fwd_a=01, fwd_b=00 for 2 cycles; branch=1 on 4 cycles with mispredict on 1; jump on 2 → fwd_cnt=8, branch_cnt=4, mispred_cnt=1, jump_cnt=2.
- Hang: STALL_LIMIT=16; PC held at 0x8 with pc_valid=1 after advancing → FAIL, fail_code=2, exactly 16 cycles after the last change; counters frozen afterwards.
- Timeout: TIMEOUT=20, END_PC never reached, PC increments each cycle → FAIL with fail_code=1; cycle_cnt=20.
- Protocol and priority:
  - mispredict=1 with branch=0 → FAIL, code 3.
  - Same cycle as pc==END_PC → PASS wins.
- Saturation and clear: CNT_W=4 with retire held high for 20 cycles → retire_cnt=15. Then clear together with retire=1 → retire_cnt=0 next cycle, state still RUN; rst in RUN → all outputs return to reset values.
